// File: rtl/axi_txn_sched.sv
// axi_txn_sched: round-robin scheduler that shares one AXI4 burst master
// among NUM_REQ command sources. One command is in flight at a time. A
// command ends when txn_done arrives or the timeout expires, and the
// requester then gets a done/error pulse. Write, read and error statistics
// are kept in saturating counters.
module axi_txn_sched #(
  parameter int NUM_REQ   = 2,     // number of requesters, 2..8
  parameter int TIMEOUT   = 1024,  // max WAIT cycles before abort, 0 = never
  parameter int TMO_WIDTH = 16,    // timeout counter width, must hold TIMEOUT
  parameter int CNT_WIDTH = 16     // statistics counter width
) (
  input  logic                   axi_aclk,
  input  logic                   axi_aresetn,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [2*NUM_REQ-1:0]   req_type,
  output logic [NUM_REQ-1:0]     req_grant,
  output logic [NUM_REQ-1:0]     req_done,
  output logic                   req_err,
  output logic                   txn_start,
  output logic [1:0]             txn_type,
  input  logic                   txn_done,
  output logic                   busy,
  output logic [CNT_WIDTH-1:0]   wr_cnt,
  output logic [CNT_WIDTH-1:0]   rd_cnt,
  output logic [CNT_WIDTH-1:0]   err_cnt
);

  localparam int IDX_W = $clog2(NUM_REQ);

  // FSM encoding
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Command type encoding shared with the AXI master
  localparam logic [1:0] TYPE_WR = 2'b01;
  localparam logic [1:0] TYPE_RD = 2'b10;

  // Last WAIT count before the abort; unused when TIMEOUT is 0
  localparam logic [TMO_WIDTH-1:0] TMO_LAST =
    (TIMEOUT == 0) ? '0 : TMO_WIDTH'(TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  logic [1:0]           state;
  logic [1:0]           next_state;
  logic [IDX_W-1:0]     rr_ptr;
  logic [TMO_WIDTH-1:0] tmo_cnt;

  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic [NUM_REQ-1:0]   win_onehot;
  logic [1:0]           win_type;
  logic                 win_legal;
  logic                 grant_fire;
  logic                 tmo_hit;

  // Saturating increment for the statistics counters
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  // Round-robin pick: first valid requester scanning from rr_ptr+1 cyclically
  always_comb begin
    int cand;
    // NOTE: every variable written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(rr_ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!win_found && req_valid[cand]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(cand);
      end
    end
  end

  assign win_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << win_idx;
  assign win_type   = req_type[{win_idx, 1'b0} +: 2];
  assign win_legal  = (win_type == TYPE_WR) || (win_type == TYPE_RD);
  assign grant_fire = (state == S_IDLE) && win_found;
  assign tmo_hit    = (TIMEOUT != 0) && (tmo_cnt == TMO_LAST);

  // Next-state logic; txn_done is only meaningful in WAIT
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (win_found) next_state = win_legal ? S_ISSUE : S_DONE;
      S_ISSUE: next_state = S_WAIT;
      S_WAIT:  if (txn_done || tmo_hit) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // State register; busy is registered from the next state so it tracks state
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      state <= S_IDLE;
      busy  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of block ordering.
      state <= next_state;
      busy  <= (next_state != S_IDLE);
    end
  end

  // Grant, latched command type and round-robin pointer
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      req_grant <= '0;
      txn_type  <= '0;
      rr_ptr    <= IDX_W'(NUM_REQ - 1);
    end else if (grant_fire) begin
      req_grant <= win_onehot;
      txn_type  <= win_type;
      rr_ptr    <= win_idx;
    end else if (state == S_DONE) begin
      req_grant <= '0;
      txn_type  <= '0;
    end
  end

  // Single-cycle start pulse, only for a legal command
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      txn_start <= 1'b0;
    end else begin
      txn_start <= grant_fire && win_legal;
    end
  end

  // Timeout counter: cleared in ISSUE, counts every WAIT cycle
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      tmo_cnt <= '0;
    end else if (state == S_ISSUE) begin
      tmo_cnt <= '0;
    end else if (state == S_WAIT) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end
  end

  // Completion pulse; txn_done beats a coincident timeout
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      req_done <= '0;
      req_err  <= 1'b0;
    end else begin
      req_done <= '0;
      req_err  <= 1'b0;
      if (grant_fire && !win_legal) begin
        req_done <= win_onehot;
        req_err  <= 1'b1;
      end else if ((state == S_WAIT) && (txn_done || tmo_hit)) begin
        req_done <= req_grant;
        req_err  <= !txn_done;
      end
    end
  end

  // Statistics, bumped once per command while in DONE
  always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
    if (!axi_aresetn) begin
      wr_cnt  <= '0;
      rd_cnt  <= '0;
      err_cnt <= '0;
    end else if (state == S_DONE) begin
      if (req_err) begin
        err_cnt <= sat_inc(err_cnt);
      end else if (txn_type == TYPE_WR) begin
        wr_cnt <= sat_inc(wr_cnt);
      end else if (txn_type == TYPE_RD) begin
        rd_cnt <= sat_inc(rd_cnt);
      end
    end
  end

endmodule

// File: tb/tb_axi_txn_sched.sv
// Bench for axi_txn_sched: directed scenarios plus randomized traffic,
// checked against a transaction-level model of the scheduler.
module tb_axi_txn_sched;

  localparam int NUM_REQ   = 2;
  localparam int TIMEOUT   = 8;
  localparam int TMO_WIDTH = 16;
  localparam int CNT_WIDTH = 16;

  logic                 axi_aclk = 1'b0;
  logic                 axi_aresetn = 1'b0;
  logic [NUM_REQ-1:0]   req_valid = '0;
  logic [2*NUM_REQ-1:0] req_type = '0;
  logic [NUM_REQ-1:0]   req_grant;
  logic [NUM_REQ-1:0]   req_done;
  logic                 req_err;
  logic                 txn_start;
  logic [1:0]           txn_type;
  logic                 txn_done = 1'b0;
  logic                 busy;
  logic [CNT_WIDTH-1:0] wr_cnt;
  logic [CNT_WIDTH-1:0] rd_cnt;
  logic [CNT_WIDTH-1:0] err_cnt;

  axi_txn_sched #(
    .NUM_REQ(NUM_REQ), .TIMEOUT(TIMEOUT),
    .TMO_WIDTH(TMO_WIDTH), .CNT_WIDTH(CNT_WIDTH)
  ) dut (
    .axi_aclk(axi_aclk), .axi_aresetn(axi_aresetn),
    .req_valid(req_valid), .req_type(req_type),
    .req_grant(req_grant), .req_done(req_done), .req_err(req_err),
    .txn_start(txn_start), .txn_type(txn_type), .txn_done(txn_done),
    .busy(busy), .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .err_cnt(err_cnt)
  );

  always #5 axi_aclk = ~axi_aclk;

  int total = 0;
  int bad = 0;

  // Reference model state
  int exp_ptr;
  int exp_wr, exp_rd, exp_err;
  int exp_starts = 0;
  int seen_starts = 0;
  int obs_win;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Counts every cycle the start pulse is high
  always @(negedge axi_aclk) if (txn_start === 1'b1) seen_starts++;

  function automatic int pick();
    for (int k = 1; k <= NUM_REQ; k++) begin
      int i;
      i = (exp_ptr + k) % NUM_REQ;
      if (req_valid[i]) return i;
    end
    return 0;
  endfunction

  function automatic logic [NUM_REQ-1:0] onehot(input int i);
    logic [NUM_REQ-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int sat_inc(input int v);
    return (v == (1 << CNT_WIDTH) - 1) ? v : v + 1;
  endfunction

  function automatic logic [1:0] rand_type();
    int r;
    r = int'($urandom_range(0, 7));
    if (r < 3) return 2'b01;
    if (r < 6) return 2'b10;
    return (r == 6) ? 2'b00 : 2'b11;
  endfunction

  task automatic model_reset();
    exp_ptr = NUM_REQ - 1;
    exp_wr  = 0;
    exp_rd  = 0;
    exp_err = 0;
  endtask

  task automatic check_counters(input string tag);
    check({tag, "_wr"},  32'(wr_cnt),  32'(exp_wr));
    check({tag, "_rd"},  32'(rd_cnt),  32'(exp_rd));
    check({tag, "_err"}, 32'(err_cnt), 32'(exp_err));
  endtask

  // One arbitration round. Called at the falling edge of an IDLE cycle with
  // at least one request driven; the master answers d WAIT cycles after
  // the start (d >= TIMEOUT means it never answers in time). Returns at the
  // falling edge of the IDLE cycle after DONE.
  task automatic run_txn(input int d, input bit spur, input bit scramble, input bit drop);
    int win;
    int done_c;
    logic [1:0] ty;
    bit legal;
    bit err;
    win   = pick();
    ty    = req_type[2*win +: 2];
    legal = (ty == 2'b01) || (ty == 2'b10);
    @(negedge axi_aclk);
    txn_done = spur;
    exp_ptr  = win;
    check("grant", 32'(req_grant), 32'(onehot(win)));
    check("txn_type", 32'(txn_type), 32'(ty));
    check("busy", 32'(busy), 32'd1);
    check("txn_start", 32'(txn_start), 32'(legal));
    check("done_early", 32'(req_done), legal ? 32'd0 : 32'(onehot(win)));
    check("err_early", 32'(req_err), 32'(!legal));
    obs_win = 0;
    for (int i = 0; i < NUM_REQ; i++) if (req_grant[i]) obs_win = i;
    err = 1'b1;
    if (legal) begin
      exp_starts++;
      err    = (d >= TIMEOUT);
      done_c = err ? TIMEOUT + 1 : d + 2;
      for (int c = 1; c <= done_c; c++) begin
        @(negedge axi_aclk);
        txn_done = 1'b0;
        if (c == 1 && scramble) begin
          req_type[2*win +: 2] = 2'($urandom);
          req_valid[win] = 1'($urandom);
        end
        if (c < done_c) begin
          check("wait_quiet", 32'({req_done, req_err, txn_start}), 32'd0);
          if (c - 1 == d) txn_done = 1'b1;
        end else begin
          check("req_done", 32'(req_done), 32'(onehot(win)));
          check("req_err", 32'(req_err), 32'(err));
          check("grant_held", 32'(req_grant), 32'(onehot(win)));
          check("type_held", 32'(txn_type), 32'(ty));
        end
      end
    end
    if (err) exp_err = sat_inc(exp_err);
    else if (ty == 2'b01) exp_wr = sat_inc(exp_wr);
    else exp_rd = sat_inc(exp_rd);
    if (drop) req_valid[win] = 1'b0;
    @(negedge axi_aclk);
    txn_done = 1'b0;
    check("idle_outs", 32'({req_grant, req_done, req_err, txn_start, busy, txn_type}), 32'd0);
    check_counters("idle");
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    // Reset state
    repeat (3) @(negedge axi_aclk);
    check("rst_outs", 32'({req_grant, req_done, req_err, txn_start, busy, txn_type}), 32'd0);
    check_counters("rst");
    axi_aresetn = 1'b1;
    @(negedge axi_aclk);

    // Round-robin: req0 write, req1 read, both held
    req_valid = 2'b11;
    req_type  = {2'b10, 2'b01};
    for (int k = 0; k < 4; k++) begin
      run_txn(int'($urandom_range(0, TIMEOUT - 2)), 1'b0, 1'b0, 1'b0);
      check("rr_order", 32'(obs_win), 32'(k % 2));
    end
    req_valid = '0;
    check("rr_wr", 32'(wr_cnt), 32'd2);
    check("rr_rd", 32'(rd_cnt), 32'd2);

    // Single write, answered after 5 WAIT cycles
    req_valid = 2'b01;
    req_type  = {2'b00, 2'b01};
    run_txn(5, 1'b0, 1'b0, 1'b1);
    check("single_wr", 32'(wr_cnt), 32'd3);

    // Illegal type on requester 1
    req_valid = 2'b10;
    req_type  = {2'b11, 2'b00};
    run_txn(0, 1'b0, 1'b0, 1'b1);
    check("illegal_err", 32'(err_cnt), 32'd1);

    // Timeout, then a late txn_done in IDLE is ignored
    req_valid = 2'b01;
    req_type  = {2'b00, 2'b01};
    run_txn(100, 1'b0, 1'b0, 1'b1);
    check("tmo_err", 32'(err_cnt), 32'd2);
    txn_done = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge axi_aclk);
      check("late_done", 32'({busy, req_done, req_err, txn_start}), 32'd0);
    end
    txn_done = 1'b0;
    check_counters("late");

    // txn_done coincident with the timeout cycle: success
    req_valid = 2'b10;
    req_type  = {2'b10, 2'b00};
    run_txn(TIMEOUT - 1, 1'b0, 1'b0, 1'b1);
    check("coincident_rd", 32'(rd_cnt), 32'd3);

    // Randomized traffic
    for (int n = 0; n < 200; n++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
          req_valid[i] = 1'b1;
          req_type[2*i +: 2] = rand_type();
        end
      end
      if (req_valid == '0) begin
        int i;
        i = int'($urandom_range(0, NUM_REQ - 1));
        req_valid[i] = 1'b1;
        req_type[2*i +: 2] = rand_type();
      end
      if ($urandom_range(0, 4) == 0) txn_done = 1'b1;
      run_txn(int'($urandom_range(0, TIMEOUT + 2)), $urandom_range(0, 3) == 0,
              $urandom_range(0, 2) == 0, 1'b1);
    end

    // Reset in the middle of WAIT
    req_valid = 2'b01;
    req_type  = {2'b00, 2'b10};
    @(negedge axi_aclk);
    exp_starts++;
    repeat (2) @(negedge axi_aclk);
    #2 axi_aresetn = 1'b0;
    #1;
    model_reset();
    check("rst_mid_outs", 32'({req_grant, req_done, req_err, txn_start, busy, txn_type}), 32'd0);
    check_counters("rst_mid");
    req_valid = '0;
    @(negedge axi_aclk);
    axi_aresetn = 1'b1;
    @(negedge axi_aclk);
    req_valid = 2'b11;
    req_type  = {2'b01, 2'b10};
    run_txn(3, 1'b0, 1'b0, 1'b1);
    check("post_rst_win", 32'(obs_win), 32'd0);
    req_valid = '0;
    @(negedge axi_aclk);

    check("start_count", 32'(seen_starts), 32'(exp_starts));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
